systolic_skew_feeder: RTL and testbench



---
 rtl/systolic_skew_feeder.sv | 141 ++++++++++++++
 tb/tb_systolic_skew_feeder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_skew_feeder.sv
// Operand feeder for the tpumac systolic array: buffers a DIM x DIM matrix and
// streams it as diagonally skewed lanes (lane i delayed i cycles) with status.
module systolic_skew_feeder #(
  parameter int unsigned BITS_AB = 8,
  parameter int unsigned DIM     = 8,
  parameter int unsigned CNT_W   = $clog2(2 * DIM)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(DIM)-1:0]   wr_row,
  input  logic [DIM*BITS_AB-1:0]   wr_data,
  input  logic                     start,
  output logic [DIM*BITS_AB-1:0]   a_out,
  output logic [DIM-1:0]           valid_out,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned ROW_W = $clog2(DIM);
  localparam int unsigned DW    = CNT_W + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(2 * DIM - 2);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [BITS_AB-1:0]   mem [DIM][DIM];
  logic                 row_ok_c;

  logic [DIM*BITS_AB-1:0] a_nxt;
  logic [DIM-1:0]         valid_nxt;
  logic                   busy_nxt;
  logic                   done_nxt;
  logic [DW-1:0]          diff_c;

  // Out-of-range rows only exist when DIM is not a power of two.
  generate
    if ((1 << ROW_W) == DIM) begin : g_pow2
      assign row_ok_c = 1'b1;
    end else begin : g_npow2
      assign row_ok_c = (wr_row < ROW_W'(DIM));
    end
  endgenerate

  // Row-write storage; writes are only accepted while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DIM; i++) begin
        for (int unsigned j = 0; j < DIM; j++) begin
          mem[i][j] <= '0;
        end
      end
    end else if (state == IDLE && wr_en && row_ok_c) begin
      for (int unsigned j = 0; j < DIM; j++) begin
        mem[wr_row][j] <= wr_data[j*BITS_AB +: BITS_AB];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = STREAM;
          cnt_nxt   = '0;
        end
      end
      STREAM: begin
        if (cnt == LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output logic: lane i carries column (cnt - i) of row i when in range.
  always_comb begin
    a_nxt     = '0;
    valid_nxt = '0;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    diff_c    = '0;
    case (state)
      IDLE: begin
        busy_nxt = start;
      end
      STREAM: begin
        busy_nxt = (cnt != LAST);
        done_nxt = (cnt == LAST);
        for (int unsigned i = 0; i < DIM; i++) begin
          diff_c = {1'b0, cnt} - DW'(i);
          if (!diff_c[CNT_W] && (diff_c[CNT_W-1:0] < CNT_W'(DIM))) begin
            a_nxt[i*BITS_AB +: BITS_AB] = mem[i][diff_c[ROW_W-1:0]];
            valid_nxt[i]                = 1'b1;
          end
        end
      end
      default: begin
        busy_nxt = 1'b0;
      end
    endcase
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out     <= '0;
      valid_out <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      a_out     <= a_nxt;
      valid_out <= valid_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed self-checking bench for systolic_skew_feeder (DIM=8, BITS_AB=8).
module tb_systolic_skew_feeder;

  localparam int unsigned DIM  = 8;
  localparam int unsigned BITS = 8;

  logic                 clk;
  logic                 rst_n;
  logic                 wr_en;
  logic [2:0]           wr_row;
  logic [DIM*BITS-1:0]  wr_data;
  logic                 start;
  logic [DIM*BITS-1:0]  a_out;
  logic [DIM-1:0]       valid_out;
  logic                 busy;
  logic                 done;

  int n_cmp;
  int n_err;

  logic [7:0]  mat [DIM][DIM];
  logic [63:0] snap [17];
  logic [63:0] a_h [32];
  logic        v0_h [32];
  logic        done_h [32];
  logic        busy_h [32];
  int          done_cnt;

  systolic_skew_feeder #(.BITS_AB(BITS), .DIM(DIM)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_row    (wr_row),
    .wr_data   (wr_data),
    .start     (start),
    .a_out     (a_out),
    .valid_out (valid_out),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected lanes/valid after edge Ek of a stream (E0 = start sampled).
  function automatic logic [63:0] exp_lanes(input int k);
    logic [63:0] r;
    int j;
    r = '0;
    for (int i = 0; i < DIM; i++) begin
      j = k - 1 - i;
      if (j >= 0 && j < DIM) r[i*BITS +: BITS] = mat[i][j];
    end
    return r;
  endfunction

  function automatic logic [7:0] exp_valid(input int k);
    logic [7:0] r;
    int j;
    r = '0;
    for (int i = 0; i < DIM; i++) begin
      j = k - 1 - i;
      if (j >= 0 && j < DIM) r[i] = 1'b1;
    end
    return r;
  endfunction

  task automatic write_row(input int r);
    wr_en  = 1'b1;
    wr_row = 3'(r);
    for (int j = 0; j < DIM; j++) wr_data[j*BITS +: BITS] = mat[r][j];
    step();
    wr_en = 1'b0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) mat[i][j] = 8'h00;
  endtask

  // Full stream with per-cycle checks; poke injects a write and start mid-stream.
  task automatic run_stream(input string tag, input bit poke);
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq({tag, "_busy_e0"}, 64'(busy), 64'd1);
    for (int k = 1; k <= 16; k++) begin
      if (poke && k == 3) begin
        wr_en   = 1'b1;
        wr_row  = 3'd0;
        wr_data = {8{8'h7F}};
        start   = 1'b1;
      end
      if (poke && k == 5) begin
        wr_en = 1'b0;
        start = 1'b0;
      end
      step();
      snap[k] = a_out;
      if (k < 16) begin
        check_eq($sformatf("%s_a_e%0d", tag, k), a_out, exp_lanes(k));
        check_eq($sformatf("%s_v_e%0d", tag, k), 64'(valid_out), 64'(exp_valid(k)));
        check_eq($sformatf("%s_done_e%0d", tag, k), 64'(done), 64'(k == 15));
        check_eq($sformatf("%s_busy_e%0d", tag, k), 64'(busy), 64'(k < 15));
      end else begin
        check_eq({tag, "_a_end"}, a_out, 64'd0);
        check_eq({tag, "_v_end"}, 64'(valid_out), 64'd0);
        check_eq({tag, "_done_end"}, 64'(done), 64'd0);
        check_eq({tag, "_busy_end"}, 64'(busy), 64'd0);
      end
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_row  = '0;
    wr_data = '0;
    start   = 1'b0;
    clear_model();

    // Reset held three cycles, then released with no writes
    repeat (3) step();
    check_eq("rst_a", a_out, 64'd0);
    check_eq("rst_v", 64'(valid_out), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    step();
    check_eq("post_rst_a", a_out, 64'd0);
    check_eq("post_rst_busy", 64'(busy), 64'd0);
    run_stream("zero", 1'b0);

    // Load mem[i][j] = 8*i+j+1
    for (int i = 0; i < DIM; i++) begin
      for (int j = 0; j < DIM; j++) mat[i][j] = 8'(8 * i + j + 1);
      write_row(i);
    end
    run_stream("ramp", 1'b0);
    check_eq("ramp_hand_e1", snap[1], 64'h0000_0000_0000_0001);
    check_eq("ramp_hand_e2", snap[2], 64'h0000_0000_0000_0902);
    check_eq("ramp_hand_e8", snap[8], 64'h3932_2B24_1D16_0F08);
    check_eq("ramp_hand_e15", snap[15], 64'h4000_0000_0000_0000);

    // Negative row 3: 8'h80..8'h87
    for (int j = 0; j < DIM; j++) mat[3][j] = 8'(8'h80 + j);
    write_row(3);
    run_stream("neg", 1'b0);
    check_eq("neg_lane3_e4", 64'(snap[4][31:24]), 64'h80);
    check_eq("neg_lane3_e11", 64'(snap[11][31:24]), 64'h87);

    // Write and start during STREAM must be ignored
    run_stream("poke", 1'b1);
    run_stream("after_poke", 1'b0);
    check_eq("after_poke_row0_e1", 64'(snap[1][7:0]), 64'h01);
    check_eq("after_poke_row0_e8", 64'(snap[8][7:0]), 64'h08);

    // Asynchronous reset mid-cycle after E5
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    check_eq("pre_arst_v", 64'(valid_out), 64'h1F);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_a", a_out, 64'd0);
    check_eq("arst_v", 64'(valid_out), 64'd0);
    check_eq("arst_busy", 64'(busy), 64'd0);
    check_eq("arst_done", 64'(done), 64'd0);
    clear_model();
    repeat (2) step();
    rst_n = 1'b1;
    step();
    run_stream("zero2", 1'b0);

    // Start held high across two streams
    for (int j = 0; j < DIM; j++) mat[0][j] = 8'(j + 1);
    write_row(0);
    start = 1'b1;
    for (int e = 0; e < 32; e++) begin
      step();
      a_h[e]    = a_out;
      v0_h[e]   = valid_out[0];
      done_h[e] = done;
      busy_h[e] = busy;
    end
    start = 1'b0;
    done_cnt = 0;
    for (int e = 0; e < 32; e++) if (done_h[e]) done_cnt++;
    check_eq("b2b_done_count", 64'(done_cnt), 64'd2);
    check_eq("b2b_done1", 64'(done_h[15]), 64'd1);
    check_eq("b2b_done1_width", 64'(done_h[16]), 64'd0);
    check_eq("b2b_done2", 64'(done_h[31]), 64'd1);
    check_eq("b2b_gap_v0", 64'(v0_h[16]), 64'd0);
    check_eq("b2b_gap_busy", 64'(busy_h[16]), 64'd1);
    check_eq("b2b_second_v0", 64'(v0_h[17]), 64'd1);
    check_eq("b2b_second_lane0", 64'(a_h[17][7:0]), 64'h01);
    step();
    check_eq("b2b_end_done", 64'(done), 64'd0);
    check_eq("b2b_end_busy", 64'(busy), 64'd0);
    check_eq("b2b_end_a", a_out, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
